// File: rtl/gpio_port.sv
// Memory-mapped GPIO port: per-pin direction, output data with atomic set/clear,
// synchronised input sampling and rise/fall edge interrupt capture.
module gpio_port #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             wr_en,
    input  logic [2:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [2:0] ADDR_MODER = 3'd0;
    localparam logic [2:0] ADDR_ODR   = 3'd1;
    localparam logic [2:0] ADDR_IDR   = 3'd2;
    localparam logic [2:0] ADDR_OSET  = 3'd3;
    localparam logic [2:0] ADDR_OCLR  = 3'd4;
    localparam logic [2:0] ADDR_RIE   = 3'd5;
    localparam logic [2:0] ADDR_FIE   = 3'd6;
    localparam logic [2:0] ADDR_ISR   = 3'd7;

    logic [WIDTH-1:0] moder;
    logic [WIDTH-1:0] odr;
    logic [WIDTH-1:0] rie;
    logic [WIDTH-1:0] fie;
    logic [WIDTH-1:0] isr;
    logic [WIDTH-1:0] isr_next;
    logic [WIDTH-1:0] isr_clr;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] set_evt;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] rd_val;
    logic             wr;
    logic             unused_wdata;

    assign wr           = ce && wr_en;
    assign wd           = wdata[WIDTH-1:0];
    assign unused_wdata = ^wdata;

    // Pad inputs are asynchronous; every pin goes through the same flop chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];
    assign rise    = sync_in & ~prev;
    assign fall    = ~sync_in & prev;
    assign set_evt = (rise & rie) | (fall & fie);

    // A new edge event beats a same-cycle W1C so no interrupt is ever lost.
    always_comb begin
        isr_clr = '0;
        if (wr && (addr == ADDR_ISR)) begin
            isr_clr = wd;
        end
        isr_next = (isr & ~isr_clr) | set_evt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            moder <= '0;
            odr   <= '0;
            rie   <= '0;
            fie   <= '0;
            isr   <= '0;
            prev  <= '0;
            irq   <= 1'b0;
        end else begin
            prev <= sync_in;
            isr  <= isr_next;
            irq  <= |isr_next;
            if (wr) begin
                case (addr)
                    ADDR_MODER: moder <= wd;
                    ADDR_ODR:   odr   <= wd;
                    ADDR_OSET:  odr   <= odr | wd;
                    ADDR_OCLR:  odr   <= odr & ~wd;
                    ADDR_RIE:   rie   <= wd;
                    ADDR_FIE:   fie   <= wd;
                    default:    ;
                endcase
            end
        end
    end

    // Write-only and out-of-cycle reads return zero rather than stale data.
    always_comb begin
        rd_val = '0;
        rdata  = '0;
        if (ce && !wr_en) begin
            case (addr)
                ADDR_MODER: rd_val = moder;
                ADDR_ODR:   rd_val = odr;
                ADDR_IDR:   rd_val = sync_in;
                ADDR_RIE:   rd_val = rie;
                ADDR_FIE:   rd_val = fie;
                ADDR_ISR:   rd_val = isr;
                default:    rd_val = '0;
            endcase
        end
        rdata[WIDTH-1:0] = rd_val;
    end

    assign gpio_out = odr;
    assign gpio_oe  = moder;

endmodule

// File: tb/tb_gpio_port.sv
// Directed bench for gpio_port: register access, input sync latency, edge interrupts
// and narrow/wide builds.
module tb_gpio_port;

    logic        clk;
    logic        reset;
    logic        ce;
    logic        wr_en;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_oe;
    logic        irq;

    logic [31:0] rdata32;
    logic [31:0] gpio_in32;
    logic [31:0] gpio_out32;
    logic [31:0] gpio_oe32;
    logic        irq32;

    logic [31:0] rdata1;
    logic [0:0]  gpio_in1;
    logic [0:0]  gpio_out1;
    logic [0:0]  gpio_oe1;
    logic        irq1;

    int checks = 0;
    int errors = 0;
    logic [31:0] r;

    gpio_port #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .ce(ce), .wr_en(wr_en), .addr(addr), .wdata(wdata),
        .rdata(rdata), .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    gpio_port #(.WIDTH(32), .SYNC_STAGES(2)) dut32 (
        .clk(clk), .reset(reset), .ce(ce), .wr_en(wr_en), .addr(addr), .wdata(wdata),
        .rdata(rdata32), .gpio_in(gpio_in32), .gpio_out(gpio_out32), .gpio_oe(gpio_oe32), .irq(irq32)
    );

    gpio_port #(.WIDTH(1), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .reset(reset), .ce(ce), .wr_en(wr_en), .addr(addr), .wdata(wdata),
        .rdata(rdata1), .gpio_in(gpio_in1), .gpio_out(gpio_out1), .gpio_oe(gpio_oe1), .irq(irq1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        ce    = 1'b1;
        wr_en = 1'b1;
        addr  = a;
        wdata = d;
        @(negedge clk);
        ce    = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        ce    = 1'b1;
        wr_en = 1'b0;
        addr  = a;
        #1 d  = rdata;
    endtask

    initial begin
        reset     = 1'b1;
        ce        = 1'b0;
        wr_en     = 1'b0;
        addr      = 3'd0;
        wdata     = 32'd0;
        gpio_in   = 8'h00;
        gpio_in32 = 32'd0;
        gpio_in1  = 1'b0;
        $display("[TB] start");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset asserted in the middle of a write must clear everything at once.
        bus_write(3'd0, 32'h0000_0055);
        check_output("moder_pre_reset", 32'(gpio_oe), 32'h55);
        @(negedge clk);
        ce = 1'b1; wr_en = 1'b1; addr = 3'd1; wdata = 32'hFF;
        #2 reset = 1'b1;
        #1;
        check_output("reset_gpio_oe", 32'(gpio_oe), 32'h0);
        check_output("reset_gpio_out", 32'(gpio_out), 32'h0);
        check_output("reset_irq", 32'(irq), 32'h0);
        check_output("reset_rdata", rdata, 32'h0);
        @(negedge clk);
        ce = 1'b0; wr_en = 1'b0;
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), r);
            check_output($sformatf("reset_reg%0d", a), r, 32'h0);
        end

        bus_write(3'd0, 32'h0000_00FF);
        bus_write(3'd1, 32'h0000_00A5);
        check_output("gpio_oe_ff", 32'(gpio_oe), 32'hFF);
        check_output("gpio_out_a5", 32'(gpio_out), 32'hA5);
        bus_write(3'd3, 32'h0000_000A);
        bus_read(3'd1, r);
        check_output("odr_after_oset", r, 32'hAF);
        bus_write(3'd4, 32'h0000_0081);
        bus_read(3'd1, r);
        check_output("odr_after_oclr", r, 32'h2E);
        check_output("gpio_out_2e", 32'(gpio_out), 32'h2E);
        bus_read(3'd3, r);
        check_output("oset_reads_0", r, 32'h0);
        bus_read(3'd4, r);
        check_output("oclr_reads_0", r, 32'h0);
        bus_write(3'd5, 32'hFFFF_FF00);
        bus_read(3'd5, r);
        check_output("rie_upper_ignored", r, 32'h0);

        // Input sync: one edge of old value, then the new value.
        @(negedge clk);
        gpio_in = 8'h3C;
        ce = 1'b1; wr_en = 1'b0; addr = 3'd2;
        #1 check_output("idr_before_edge", rdata, 32'h0);
        @(posedge clk);
        #1 check_output("idr_after_edge1", rdata, 32'h0);
        @(posedge clk);
        #1 check_output("idr_after_edge2", rdata, 32'h3C);
        @(negedge clk);
        wr_en = 1'b1; wdata = 32'h0000_00FF;
        #1 check_output("rdata_in_write", rdata, 32'h0);
        @(negedge clk);
        ce = 1'b0; wr_en = 1'b0;
        bus_read(3'd2, r);
        check_output("idr_write_ignored", r, 32'h3C);
        bus_read(3'd7, r);
        check_output("isr_no_enable", r, 32'h0);

        // Edge interrupts.
        bus_write(3'd5, 32'h0000_0001);
        bus_write(3'd6, 32'h0000_0002);
        @(negedge clk);
        gpio_in = 8'h02;
        repeat (4) @(negedge clk);
        bus_read(3'd7, r);
        check_output("isr_unenabled_edges", r, 32'h0);
        check_output("irq_idle", 32'(irq), 32'h0);
        @(negedge clk);
        gpio_in = 8'h05;
        repeat (4) @(negedge clk);
        bus_read(3'd7, r);
        check_output("isr_rise_fall", r, 32'h03);
        check_output("isr_pin2_clear", 32'(r[2]), 32'h0);
        check_output("irq_set", 32'(irq), 32'h1);

        bus_write(3'd7, 32'h0000_0001);
        bus_read(3'd7, r);
        check_output("isr_w1c_bit0", r, 32'h02);
        check_output("irq_still_set", 32'(irq), 32'h1);
        bus_write(3'd7, 32'h0000_0002);
        bus_read(3'd7, r);
        check_output("isr_w1c_all", r, 32'h0);
        @(negedge clk);
        check_output("irq_dropped", 32'(irq), 32'h0);

        // Rise on pin 0 detected in the same cycle as a W1C of bit 0.
        gpio_in = 8'h04;
        repeat (4) @(negedge clk);
        bus_read(3'd7, r);
        check_output("isr_fall_unenabled", r, 32'h0);
        @(negedge clk);
        ce = 1'b0; wr_en = 1'b0;
        gpio_in = 8'h05;
        @(negedge clk);
        @(negedge clk);
        ce = 1'b1; wr_en = 1'b1; addr = 3'd7; wdata = 32'h1;
        @(negedge clk);
        ce = 1'b0; wr_en = 1'b0;
        bus_read(3'd7, r);
        check_output("isr_set_beats_clear", r, 32'h01);
        check_output("irq_set_beats_clear", 32'(irq), 32'h1);

        // Wide and narrow builds.
        bus_write(3'd1, 32'hFFFF_FFFF);
        @(negedge clk);
        ce = 1'b1; wr_en = 1'b0; addr = 3'd1;
        #1;
        check_output("odr_width32", rdata32, 32'hFFFF_FFFF);
        check_output("odr_width1", rdata1, 32'h0000_0001);
        check_output("odr_width8", rdata, 32'h0000_00FF);

        // Async reset wipes a pending interrupt immediately.
        @(negedge clk);
        ce = 1'b1; wr_en = 1'b0; addr = 3'd7;
        #2 reset = 1'b1;
        #1;
        check_output("reset_clears_irq", 32'(irq), 32'h0);
        check_output("reset_clears_isr", rdata, 32'h0);
        check_output("reset_clears_out", 32'(gpio_out), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        ce = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
